brick_move_scheduler: RTL and testbench

- Game-level sequencer for the falling brick.
- Arbitrates keyboard move requests, gravity ticks and hard drop into one trial position at a time, and runs each trial through the external collision checker.
- Commits or rejects each trial. On landing it sequences place, line clear and spawn of the next brick.
- Sits between the keyboard/clock-divider pulses and the board-storage, collision-check and display logic.

---
 rtl/brick_move_scheduler.sv | 269 ++++++++++++++++++++++++++
 tb/tb_brick_move_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_move_scheduler.sv
// Falling-brick sequencer: arbitrates keys/gravity/drop into collision-checked trials, then place/clear/spawn.
// Latency: request -> cur_* update is 1 + checker latency + 1 cycles; one trial outstanding at a time.
// Backpressure: chk/place/clear requests are held until their ack; keys outside WAIT are dropped, ticks merge
// into a one-deep pending flag. Optional lock delay on gravity landings is enabled by defining LOCK_DELAY_EN.
module brick_move_scheduler #(
  parameter int X_W     = 4,
  parameter int Y_W     = 5,
  parameter int SPAWN_X = 6,
  parameter int SPAWN_Y = 18
`ifdef LOCK_DELAY_EN
  , parameter int LOCK_TICKS = 2
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_down,
  input  logic               key_rot,
  input  logic               key_drop,
  input  logic [2:0]         next_type,
  output logic               chk_req,
  output logic [X_W+Y_W-1:0] chk_pos,
  output logic [1:0]         chk_dir,
  output logic [2:0]         chk_type,
  input  logic               chk_ack,
  input  logic               chk_collided,
  output logic [X_W+Y_W-1:0] cur_pos,
  output logic [1:0]         cur_dir,
  output logic [2:0]         cur_type,
  output logic               place_req,
  input  logic               place_ack,
  output logic               clear_req,
  input  logic               clear_ack,
  output logic               game_over
);

  localparam int P_W = X_W + Y_W;
  localparam logic [X_W-1:0] SPX   = SPAWN_X[X_W-1:0];
  localparam logic [Y_W-1:0] SPY   = SPAWN_Y[Y_W-1:0];
  localparam logic [P_W-1:0] SPAWN_POS = {SPX, SPY};
  localparam logic [X_W-1:0] X_ONE = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] Y_ONE = {{(Y_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_WAIT, ST_CHECK, ST_PLACE, ST_CLEAR, ST_SPAWN, ST_SPAWN_CHK, ST_OVER
  } state_e;

  typedef enum logic [1:0] {K_MOVE, K_GRAV, K_DROP} kind_e;

  state_e         state_q, state_d;
  kind_e          kind_q, kind_d;
  logic [P_W-1:0] cur_pos_q, cur_pos_d, trl_pos_q, trl_pos_d;
  logic [1:0]     cur_dir_q, cur_dir_d, trl_dir_q, trl_dir_d;
  logic [2:0]     cur_type_q, cur_type_d, trl_type_q, trl_type_d;
  logic           chk_req_q, chk_req_d;
  logic           tick_pend_q, tick_pend_d;

  // WAIT-state candidate trial
  logic           go;
  logic [P_W-1:0] n_pos;
  logic [1:0]     n_dir;
  kind_e          n_kind;

`ifdef LOCK_DELAY_EN
  localparam int LC_W = (LOCK_TICKS > 0) ? $clog2(LOCK_TICKS + 1) : 1;
  localparam logic [LC_W-1:0] LOCK_MAX = LOCK_TICKS[LC_W-1:0];
  localparam logic [LC_W-1:0] LC_ONE   = {{(LC_W-1){1'b0}}, 1'b1};
  logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
`endif

  // Field arithmetic wraps modulo the field width.
  function automatic logic [P_W-1:0] dec_y(input logic [P_W-1:0] p);
    return {p[P_W-1:Y_W], p[Y_W-1:0] - Y_ONE};
  endfunction

  function automatic logic [P_W-1:0] dec_x(input logic [P_W-1:0] p);
    return {p[P_W-1:Y_W] - X_ONE, p[Y_W-1:0]};
  endfunction

  function automatic logic [P_W-1:0] inc_x(input logic [P_W-1:0] p);
    return {p[P_W-1:Y_W] + X_ONE, p[Y_W-1:0]};
  endfunction

  // Next-state logic: request arbitration, checker handshake and landing sequence.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cur_pos_d   = cur_pos_q;
    cur_dir_d   = cur_dir_q;
    cur_type_d  = cur_type_q;
    trl_pos_d   = trl_pos_q;
    trl_dir_d   = trl_dir_q;
    trl_type_d  = trl_type_q;
    chk_req_d   = chk_req_q;
    tick_pend_d = tick_pend_q;
    go          = 1'b0;
    n_pos       = cur_pos_q;
    n_dir       = cur_dir_q;
    n_kind      = K_MOVE;
`ifdef LOCK_DELAY_EN
    lock_cnt_d  = lock_cnt_q;
`endif

    // Ticks that cannot be served now are remembered (merged) for the next WAIT.
    if (tick && (state_q != ST_WAIT) && (state_q != ST_OVER)) begin
      tick_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_WAIT: begin
        go = 1'b1;
        if (key_drop) begin
          n_pos  = dec_y(cur_pos_q);
          n_kind = K_DROP;
        end else if (tick || tick_pend_q) begin
          n_pos       = dec_y(cur_pos_q);
          n_kind      = K_GRAV;
          tick_pend_d = 1'b0;
        end else if (key_down) begin
          n_pos = dec_y(cur_pos_q);
        end else if (key_rot) begin
          n_dir = cur_dir_q + 2'd1;
        end else if (key_left) begin
          n_pos = dec_x(cur_pos_q);
        end else if (key_right) begin
          n_pos = inc_x(cur_pos_q);
        end else begin
          go = 1'b0;
        end
        if (go) begin
          trl_pos_d  = n_pos;
          trl_dir_d  = n_dir;
          trl_type_d = cur_type_q;
          kind_d     = n_kind;
          chk_req_d  = 1'b1;
          state_d    = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (!chk_req_q) begin
          // One idle cycle between successive drop steps, then re-issue.
          chk_req_d = 1'b1;
        end else if (chk_ack) begin
          chk_req_d = 1'b0;
          if (!chk_collided) begin
            cur_pos_d = trl_pos_q;
            cur_dir_d = trl_dir_q;
            if (kind_q == K_DROP) begin
              trl_pos_d = dec_y(trl_pos_q);
            end else begin
              state_d = ST_WAIT;
            end
`ifdef LOCK_DELAY_EN
            if (kind_q == K_MOVE) lock_cnt_d = '0;
`endif
          end else begin
            unique case (kind_q)
              K_MOVE: state_d = ST_WAIT;
`ifdef LOCK_DELAY_EN
              K_GRAV: begin
                if (lock_cnt_q == LOCK_MAX) begin
                  state_d = ST_PLACE;
                end else begin
                  lock_cnt_d = lock_cnt_q + LC_ONE;
                  state_d    = ST_WAIT;
                end
              end
`else
              K_GRAV: state_d = ST_PLACE;
`endif
              default: state_d = ST_PLACE;
            endcase
          end
        end
      end

      ST_PLACE: begin
        if (place_ack) state_d = ST_CLEAR;
      end

      ST_CLEAR: begin
        if (clear_ack) begin
          state_d     = ST_SPAWN;
          tick_pend_d = 1'b0;
        end
      end

      ST_SPAWN: begin
        cur_pos_d  = SPAWN_POS;
        cur_dir_d  = 2'd0;
        cur_type_d = (next_type == 3'd0) ? 3'd1 : next_type;
        trl_pos_d  = SPAWN_POS;
        trl_dir_d  = 2'd0;
        trl_type_d = (next_type == 3'd0) ? 3'd1 : next_type;
        chk_req_d  = 1'b1;
        state_d    = ST_SPAWN_CHK;
`ifdef LOCK_DELAY_EN
        lock_cnt_d = '0;
`endif
      end

      ST_SPAWN_CHK: begin
        if (chk_req_q && chk_ack) begin
          chk_req_d = 1'b0;
          state_d   = chk_collided ? ST_OVER : ST_WAIT;
        end
      end

      ST_OVER: begin
        chk_req_d = 1'b0;
      end

      default: begin
        state_d   = ST_WAIT;
        chk_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      kind_q      <= K_MOVE;
      cur_pos_q   <= SPAWN_POS;
      cur_dir_q   <= 2'd0;
      cur_type_q  <= 3'd1;
      trl_pos_q   <= SPAWN_POS;
      trl_dir_q   <= 2'd0;
      trl_type_q  <= 3'd1;
      chk_req_q   <= 1'b0;
      tick_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cur_pos_q   <= cur_pos_d;
      cur_dir_q   <= cur_dir_d;
      cur_type_q  <= cur_type_d;
      trl_pos_q   <= trl_pos_d;
      trl_dir_q   <= trl_dir_d;
      trl_type_q  <= trl_type_d;
      chk_req_q   <= chk_req_d;
      tick_pend_q <= tick_pend_d;
    end
  end

`ifdef LOCK_DELAY_EN
  // Lock-delay counter of collided gravity trials.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_cnt_q <= '0;
    else        lock_cnt_q <= lock_cnt_d;
  end
`endif

  assign chk_req   = chk_req_q;
  assign chk_pos   = trl_pos_q;
  assign chk_dir   = trl_dir_q;
  assign chk_type  = trl_type_q;
  assign cur_pos   = cur_pos_q;
  assign cur_dir   = cur_dir_q;
  assign cur_type  = cur_type_q;
  assign place_req = (state_q == ST_PLACE);
  assign clear_req = (state_q == ST_CLEAR);
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_brick_move_scheduler.sv
// Directed bench for brick_move_scheduler: moves, rotation, wrap, drop, landing, spawn, game over, reset.
// All stimulus is applied and all outputs are sampled on the falling clock edge.
// The bench models the collision checker, board-place and line-clear responders itself.
module tb_brick_move_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_down = 1'b0, key_rot = 1'b0, key_drop = 1'b0;
  logic [2:0] next_type = 3'd1;
  logic       chk_req;
  logic [8:0] chk_pos;
  logic [1:0] chk_dir;
  logic [2:0] chk_type;
  logic       chk_ack = 1'b0, chk_collided = 1'b0;
  logic [8:0] cur_pos;
  logic [1:0] cur_dir;
  logic [2:0] cur_type;
  logic       place_req, place_ack = 1'b0;
  logic       clear_req, clear_ack = 1'b0;
  logic       game_over;

  int total = 0;
  int bad = 0;
  int last_waits = 0;

  brick_move_scheduler dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rot(key_rot), .key_drop(key_drop), .next_type(next_type),
    .chk_req(chk_req), .chk_pos(chk_pos), .chk_dir(chk_dir), .chk_type(chk_type),
    .chk_ack(chk_ack), .chk_collided(chk_collided),
    .cur_pos(cur_pos), .cur_dir(cur_dir), .cur_type(cur_type),
    .place_req(place_req), .place_ack(place_ack),
    .clear_req(clear_req), .clear_ack(clear_ack), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] P(input int x, input int y);
    logic [8:0] r;
    r = {x[3:0], y[4:0]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on any combination of request inputs.
  task automatic pulse(input bit l, input bit r, input bit d, input bit rt, input bit dr, input bit tk);
    key_left = l; key_right = r; key_down = d; key_rot = rt; key_drop = dr; tick = tk;
    @(negedge clk);
    key_left = 0; key_right = 0; key_down = 0; key_rot = 0; key_drop = 0; tick = 0;
  endtask

  task automatic wait_req();
    last_waits = 0;
    while (chk_req !== 1'b1 && last_waits < 20) begin
      @(negedge clk);
      last_waits++;
    end
    if (chk_req !== 1'b1) check("chk_req timeout", chk_req, 1);
  endtask

  // Checker answers lat cycles after it sees the request.
  task automatic serve(input int lat, input bit coll);
    repeat (lat - 1) @(negedge clk);
    chk_ack = 1'b1; chk_collided = coll;
    @(negedge clk);
    chk_ack = 1'b0; chk_collided = 1'b0;
  endtask

  task automatic trial(input string tag, input logic [8:0] pos, input logic [1:0] dir,
                       input logic [2:0] typ, input int lat, input bit coll);
    wait_req();
    check({tag, " chk_pos"}, chk_pos, pos);
    check({tag, " chk_dir"}, chk_dir, dir);
    check({tag, " chk_type"}, chk_type, typ);
    serve(lat, coll);
    check({tag, " chk_req fall"}, chk_req, 0);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (chk_req === 1'b1) seen++;
    end
    check(tag, seen, 0);
  endtask

  // Place and clear handshakes; returns in SPAWN.
  task automatic land(input logic [2:0] nt);
    check("land place_req", place_req, 1);
    next_type = nt;
    place_ack = 1'b1;
    @(negedge clk);
    place_ack = 1'b0;
    check("land place_req low", place_req, 0);
    check("land clear_req", clear_req, 1);
    clear_ack = 1'b1;
    @(negedge clk);
    clear_ack = 1'b0;
    check("land clear_req low", clear_req, 0);
  endtask

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst cur_pos", cur_pos, P(6, 18));
    check("rst cur_dir", cur_dir, 0);
    check("rst cur_type", cur_type, 1);
    check("rst chk_req", chk_req, 0);
    check("rst place_req", place_req, 0);
    check("rst clear_req", clear_req, 0);
    check("rst game_over", game_over, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Left move, checker free after 2 cycles
    pulse(1, 0, 0, 0, 0, 0);
    trial("left", P(5, 18), 0, 1, 2, 0);
    check("left cur_pos", cur_pos, P(5, 18));
    check("left place_req", place_req, 0);

    // Rotation collided: no change, no place
    pulse(0, 0, 0, 1, 0, 0);
    trial("rot coll", P(5, 18), 1, 1, 1, 1);
    check("rot coll cur_dir", cur_dir, 0);
    check("rot coll place_req", place_req, 0);

    // rot beats left
    pulse(1, 0, 0, 1, 0, 0);
    trial("rot>left", P(5, 18), 1, 1, 1, 0);
    check("rot>left cur_dir", cur_dir, 1);

    // down beats rot; collided move does not land
    pulse(0, 0, 1, 1, 0, 0);
    trial("down>rot", P(5, 17), 1, 1, 1, 1);
    check("down coll cur_pos", cur_pos, P(5, 18));
    check("down coll place_req", place_req, 0);

    // x wraps below 0, then back above 15
    for (int i = 1; i <= 6; i++) begin
      pulse(1, 0, 0, 0, 0, 0);
      trial("wrap left", P(5 - i, 18), 1, 1, 1, 0);
    end
    check("wrap cur_pos", cur_pos, P(15, 18));
    pulse(0, 1, 0, 0, 0, 0);
    trial("wrap right", P(0, 18), 1, 1, 1, 0);
    check("wrap right cur_pos", cur_pos, P(0, 18));

    // Hard drop: free at y=17..11, collided at y=10
    pulse(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      trial("drop", P(0, 17 - i), 1, 1, 1, (i == 7));
      if (i > 0) check("drop gap", last_waits, 1);
    end
    check("drop cur_pos", cur_pos, P(0, 11));

    // Ticks during PLACE are discarded at SPAWN
    pulse(0, 0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 0, 1);
    land(3'd3);
    trial("spawn", P(6, 18), 0, 3, 2, 0);
    check("spawn cur_pos", cur_pos, P(6, 18));
    check("spawn cur_type", cur_type, 3);
    check("spawn cur_dir", cur_dir, 0);
    quiet("place ticks cleared", 6);

    // tick + key together: gravity wins, key dropped
    pulse(1, 0, 0, 0, 0, 1);
    trial("tick>left", P(6, 17), 0, 3, 1, 0);
    check("tick>left cur_pos", cur_pos, P(6, 17));
    quiet("key dropped", 4);

`ifdef LOCK_DELAY_EN
    // Lock delay: move between collided ticks restarts the count
    pulse(0, 0, 0, 0, 0, 1);
    trial("lock t1", P(6, 16), 0, 3, 1, 1);
    check("lock t1 place_req", place_req, 0);
    pulse(1, 0, 0, 0, 0, 0);
    trial("lock move", P(5, 17), 0, 3, 1, 0);
    pulse(0, 0, 0, 0, 0, 1);
    trial("lock m1", P(5, 16), 0, 3, 1, 1);
    check("lock m1 place_req", place_req, 0);
    pulse(0, 0, 0, 0, 0, 1);
    trial("lock m2", P(5, 16), 0, 3, 1, 1);
    check("lock m2 place_req", place_req, 0);
    pulse(0, 0, 0, 0, 0, 1);
    trial("lock m3", P(5, 16), 0, 3, 1, 1);
`else
    // Collided gravity lands at once
    pulse(0, 0, 0, 0, 0, 1);
    trial("grav coll", P(6, 16), 0, 3, 1, 1);
`endif
    land(3'd0);

    // Ticks during SPAWN_CHK yield exactly one gravity trial; type 0 maps to 1
    wait_req();
    pulse(0, 0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 0, 1);
    check("spawn2 chk_pos", chk_pos, P(6, 18));
    check("spawn2 chk_type", chk_type, 1);
    serve(1, 0);
    check("spawn2 cur_type", cur_type, 1);
    trial("pend grav", P(6, 17), 0, 1, 1, 0);
    quiet("one grav only", 6);

    // Game over on collided spawn
    pulse(0, 0, 0, 0, 1, 0);
    trial("drop2", P(6, 16), 0, 1, 1, 1);
    land(3'd2);
    trial("spawn over", P(6, 18), 0, 2, 1, 1);
    check("over game_over", game_over, 1);
    check("over place_req", place_req, 0);
    pulse(1, 0, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 0, 1);
    pulse(0, 0, 0, 0, 1, 0);
    quiet("over ignores inputs", 5);
    check("over sticky", game_over, 1);

    // Async reset restores state
    rst_n = 1'b0;
    #1;
    check("rst2 cur_pos", cur_pos, P(6, 18));
    check("rst2 game_over", game_over, 0);
    check("rst2 cur_type", cur_type, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-handshake; late ack ignored
    pulse(0, 1, 0, 0, 0, 0);
    check("mid req", chk_req, 1);
    check("mid chk_pos", chk_pos, P(7, 18));
    rst_n = 1'b0;
    #1;
    check("mid rst chk_req", chk_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_ack = 1'b1;
    @(negedge clk);
    chk_ack = 1'b0;
    check("late ack cur_pos", cur_pos, P(6, 18));
    quiet("late ack quiet", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
